// File: rtl/wb_arbiter_if.sv
// Bundle of requester, write-port and scoreboard signals for wb_arbiter.
// The arbiter uses the slave view; requesters and the register file use the master view.
interface wb_arbiter_if;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [19:0]  req_rd;
    logic [127:0] req_data;
    logic [3:0]   req_fpr;

    logic         reg_write_o;
    logic [4:0]   write_reg;
    logic [31:0]  write_data;
    logic         FPR_GPR_sel;
    logic [1:0]   grant_id;

    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_fpr;
    logic [4:0]   query_rs1;
    logic [4:0]   query_rs2;
    logic         query_fpr;
    logic         rs1_busy;
    logic         rs2_busy;

    modport slave (
        input  req_valid, req_rd, req_data, req_fpr,
        input  issue_valid, issue_rd, issue_fpr, query_rs1, query_rs2, query_fpr,
        output req_ready, reg_write_o, write_reg, write_data, FPR_GPR_sel, grant_id,
        output rs1_busy, rs2_busy
    );

    modport master (
        output req_valid, req_rd, req_data, req_fpr,
        output issue_valid, issue_rd, issue_fpr, query_rs1, query_rs2, query_fpr,
        input  req_ready, reg_write_o, write_reg, write_data, FPR_GPR_sel, grant_id,
        input  rs1_busy, rs2_busy
    );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter for ALU/LSU/MUL/FPU with a registered register-file write port.
// Define WB_SCOREBOARD_EN to include the GPR/FPR busy-bit scoreboard.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave wb
);

    logic [1:0]  ptr_q, ptr_d;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [1:0]  search_idx;
    logic [3:0]  req_ready;

    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic        sel_fpr;

    logic        reg_write_q, reg_write_d;
    logic [4:0]  write_reg_q, write_reg_d;
    logic [31:0] write_data_q, write_data_d;
    logic        fpr_sel_q, fpr_sel_d;
    logic [1:0]  grant_id_q, grant_id_d;

    // ptr_q holds the last granted index; search starts one past it
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        search_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            search_idx = ptr_q + 2'(k);
            if (!grant_valid && wb.req_valid[search_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = search_idx;
            end
        end
        if (rst) begin
            grant_valid = 1'b0;
        end
    end

    always_comb begin
        req_ready = 4'b0000;
        if (grant_valid) begin
            req_ready = 4'b0001 << grant_idx;
        end
    end

    assign wb.req_ready = req_ready;

    always_comb begin
        sel_rd   = wb.req_rd[5*grant_idx +: 5];
        sel_data = wb.req_data[32*grant_idx +: 32];
        sel_fpr  = wb.req_fpr[grant_idx];
    end

    // A granted requester always has valid high, so a grant is a transfer
    always_comb begin
        ptr_d        = ptr_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        fpr_sel_d    = fpr_sel_q;
        grant_id_d   = grant_id_q;
        if (grant_valid) begin
            ptr_d        = grant_idx;
            reg_write_d  = sel_fpr || (sel_rd != 5'd0);
            write_reg_d  = sel_rd;
            write_data_d = sel_data;
            fpr_sel_d    = sel_fpr;
            grant_id_d   = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= 2'd3;
            reg_write_q  <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= 32'd0;
            fpr_sel_q    <= 1'b0;
            grant_id_q   <= 2'd0;
        end else begin
            ptr_q        <= ptr_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            fpr_sel_q    <= fpr_sel_d;
            grant_id_q   <= grant_id_d;
        end
    end

    assign wb.reg_write_o = reg_write_q;
    assign wb.write_reg   = write_reg_q;
    assign wb.write_data  = write_data_q;
    assign wb.FPR_GPR_sel = fpr_sel_q;
    assign wb.grant_id    = grant_id_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] gpr_busy_q, gpr_busy_d;
    logic [31:0] fpr_busy_q, fpr_busy_d;

    // Clear on write-back first, then set on issue, so a same-edge issue wins
    always_comb begin
        gpr_busy_d = gpr_busy_q;
        fpr_busy_d = fpr_busy_q;
        if (grant_valid) begin
            if (sel_fpr) begin
                fpr_busy_d[sel_rd] = 1'b0;
            end else begin
                gpr_busy_d[sel_rd] = 1'b0;
            end
        end
        if (wb.issue_valid) begin
            if (wb.issue_fpr) begin
                fpr_busy_d[wb.issue_rd] = 1'b1;
            end else begin
                gpr_busy_d[wb.issue_rd] = 1'b1;
            end
        end
        gpr_busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gpr_busy_q <= 32'd0;
            fpr_busy_q <= 32'd0;
        end else begin
            gpr_busy_q <= gpr_busy_d;
            fpr_busy_q <= fpr_busy_d;
        end
    end

    assign wb.rs1_busy = wb.query_fpr ? fpr_busy_q[wb.query_rs1] : gpr_busy_q[wb.query_rs1];
    assign wb.rs2_busy = wb.query_fpr ? fpr_busy_q[wb.query_rs2] : gpr_busy_q[wb.query_rs2];
`else
    logic unused_sb;
    assign unused_sb   = ^{wb.issue_valid, wb.issue_rd, wb.issue_fpr,
                           wb.query_rs1, wb.query_rs2, wb.query_fpr};
    assign wb.rs1_busy = 1'b0;
    assign wb.rs2_busy = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized self-checking bench for wb_arbiter against a behavioural write-back model.
// Directed reset / round-robin / x0 / f0 / scoreboard cases run first, then random traffic.
module tb_wb_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if wb();

    wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // requester stimulus state
    logic [3:0]  v;
    logic [4:0]  rd   [4];
    logic [31:0] data [4];
    logic        fpr  [4];
    logic        iv, ifpr, qf;
    logic [4:0]  ird, q1, q2;

    // reference model
    int          m_last;
    logic        m_we, m_fsel;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic [1:0]  m_gid;
    logic        m_gb [32];
    logic        m_fb [32];

    // observed values from the most recent step
    logic [3:0]  obs_ready;
    logic        obs_we, obs_sel, obs_rs1;
    logic [4:0]  obs_reg;
    logic [31:0] obs_data;
    logic [1:0]  obs_gid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_busy(input logic [4:0] r);
`ifdef WB_SCOREBOARD_EN
        return qf ? m_fb[r] : m_gb[r];
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        logic [19:0]  prd;
        logic [127:0] pdata;
        logic [3:0]   pfpr;
        for (int i = 0; i < 4; i++) begin
            prd[5*i +: 5]    = rd[i];
            pdata[32*i +: 32] = data[i];
            pfpr[i]          = fpr[i];
        end
        wb.req_valid   = v;
        wb.req_rd      = prd;
        wb.req_data    = pdata;
        wb.req_fpr     = pfpr;
        wb.issue_valid = iv;
        wb.issue_rd    = ird;
        wb.issue_fpr   = ifpr;
        wb.query_rs1   = q1;
        wb.query_rs2   = q2;
        wb.query_fpr   = qf;
    endtask

    task automatic model_reset();
        m_last = 3;
        m_we   = 1'b0;
        m_fsel = 1'b0;
        m_reg  = 5'd0;
        m_data = 32'd0;
        m_gid  = 2'd0;
        for (int r = 0; r < 32; r++) begin
            m_gb[r] = 1'b0;
            m_fb[r] = 1'b0;
        end
    endtask

    task automatic new_txn(input int i);
        v[i]    = 1'b1;
        rd[i]   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        data[i] = $urandom;
        fpr[i]  = 1'($urandom_range(0, 1));
    endtask

    // mode 0: requests stay up, 1: granted request drops, 2: random traffic
    task automatic step(input int mode);
        int         g;
        logic [3:0] exp_ready;
        drive();
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int k = 1; k <= 4; k++) begin
                int j;
                j = (m_last + k) % 4;
                if (g < 0 && v[j]) g = j;
            end
        end
        exp_ready = (g < 0) ? 4'b0000 : (4'b0001 << g);
        obs_ready = wb.req_ready;
        obs_we    = wb.reg_write_o;
        obs_reg   = wb.write_reg;
        obs_data  = wb.write_data;
        obs_sel   = wb.FPR_GPR_sel;
        obs_gid   = wb.grant_id;
        obs_rs1   = wb.rs1_busy;
        chk("req_ready", wb.req_ready, exp_ready);
        chk("reg_write_o", wb.reg_write_o, m_we);
        chk("write_reg", wb.write_reg, m_reg);
        chk("write_data", wb.write_data, m_data);
        chk("fpr_gpr_sel", wb.FPR_GPR_sel, m_fsel);
        chk("grant_id", wb.grant_id, m_gid);
        chk("rs1_busy", wb.rs1_busy, exp_busy(q1));
        chk("rs2_busy", wb.rs2_busy, exp_busy(q2));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_we = 1'b0;
            if (g >= 0) begin
                m_we   = fpr[g] || (rd[g] != 5'd0);
                m_reg  = rd[g];
                m_data = data[g];
                m_fsel = fpr[g];
                m_gid  = 2'(g);
                m_last = g;
                if (fpr[g]) m_fb[rd[g]] = 1'b0;
                else        m_gb[rd[g]] = 1'b0;
            end
            if (iv) begin
                if (ifpr)            m_fb[ird] = 1'b1;
                else if (ird != 5'd0) m_gb[ird] = 1'b1;
            end
        end
        #1;
        if (mode >= 1 && g >= 0) v[g] = 1'b0;
        if (mode == 2) begin
            for (int i = 0; i < 4; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) new_txn(i);
            end
            iv   = 1'($urandom_range(0, 1));
            ird  = 5'($urandom_range(0, 7));
            ifpr = 1'($urandom_range(0, 1));
            q1   = 5'($urandom_range(0, 7));
            q2   = 5'($urandom_range(0, 7));
            qf   = 1'($urandom_range(0, 1));
            rst  = ($urandom_range(0, 63) == 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        v = 4'b0000;
        iv = 1'b0; ifpr = 1'b0; ird = 5'd0;
        q1 = 5'd0; q2 = 5'd0; qf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 5'(i + 1); data[i] = 32'h1000 + i; fpr[i] = 1'b0;
        end
        drive();
        @(posedge clk);
        model_reset();
        #1;

        // reset with all requesters pending, then continuous round-robin
        v = 4'b1111;
        step(0);
        step(0);
        chk("rst_ready", obs_ready, 4'b0000);
        rst = 1'b0;
        step(0);
        chk("post_rst_ready", obs_ready, 4'b0001);
        chk("post_rst_we", obs_we, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(0);
            chk("rr_ready", obs_ready, 4'b0001 << (i % 4));
            chk("rr_we", obs_we, 1'b1);
            chk("rr_reg", obs_reg, ((i - 1) % 4) + 1);
        end
        v = 4'b0000;
        step(1);
        step(1);

        // ALU write to x0: presented but no strobe
        v[0] = 1'b1; rd[0] = 5'd0; data[0] = 32'hDEADBEEF; fpr[0] = 1'b0;
        step(1);
        chk("x0_ready", obs_ready, 4'b0001);
        step(1);
        chk("x0_data", obs_data, 32'hDEADBEEF);
        chk("x0_we", obs_we, 1'b0);

        // FPU write to f0 is a normal write
        v[3] = 1'b1; rd[3] = 5'd0; data[3] = 32'h3F800000; fpr[3] = 1'b1;
        step(1);
        step(1);
        chk("f0_we", obs_we, 1'b1);
        chk("f0_sel", obs_sel, 1'b1);
        chk("f0_reg", obs_reg, 5'd0);
        chk("f0_gid", obs_gid, 2'd3);

        // reset with LSU and MUL pending: nothing written, LSU first afterwards
        rst = 1'b1;
        v[1] = 1'b1; rd[1] = 5'd9;  data[1] = 32'h11111111; fpr[1] = 1'b0;
        v[2] = 1'b1; rd[2] = 5'd10; data[2] = 32'h22222222; fpr[2] = 1'b0;
        step(1);
        step(1);
        chk("rst2_ready", obs_ready, 4'b0000);
        rst = 1'b0;
        step(1);
        chk("rst2_we", obs_we, 1'b0);
        chk("rst2_first", obs_ready, 4'b0010);
        step(1);
        chk("rst2_lsu_we", obs_we, 1'b1);
        chk("rst2_lsu_gid", obs_gid, 2'd1);
        step(1);

        // scoreboard: issue x5, clear by MUL write, then issue/clear collision
        iv = 1'b1; ird = 5'd5; ifpr = 1'b0; q1 = 5'd5; q2 = 5'd0; qf = 1'b0;
        step(1);
        iv = 1'b0;
        step(1);
`ifdef WB_SCOREBOARD_EN
        chk("sb_set", obs_rs1, 1'b1);
`else
        chk("sb_off", obs_rs1, 1'b0);
`endif
        v[2] = 1'b1; rd[2] = 5'd5; data[2] = 32'h55; fpr[2] = 1'b0;
        step(1);
        step(1);
        chk("sb_clr_we", obs_we, 1'b1);
        chk("sb_clr", obs_rs1, 1'b0);
        iv = 1'b1; ird = 5'd5; ifpr = 1'b0;
        v[2] = 1'b1; rd[2] = 5'd5; data[2] = 32'h66; fpr[2] = 1'b0;
        step(1);
        iv = 1'b0;
        step(1);
`ifdef WB_SCOREBOARD_EN
        chk("sb_set_wins", obs_rs1, 1'b1);
`else
        chk("sb_off2", obs_rs1, 1'b0);
`endif

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
